// File: rtl/pulse_channel_gen.sv
// Square-wave APU channel: frequency timer, duty sequencer, envelope, length counter, optional sweep.
// Define PULSE_CUSTOM_DUTY_EN to make duty 3 use the programmable pattern register at addr 5.
module pulse_channel_gen #(
  parameter int FREQ_W    = 11,
  parameter int LEN_W     = 6,
  parameter int HAS_SWEEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk_en,
  input  logic       clk256_en,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic [7:0] rdata,
  output logic [3:0] wave,
  output logic [3:0] volume_out,
  output logic       active
);

  logic [2:0]        per_q, per_d, sh_q, sh_d;
  logic              neg_q, neg_d;
  logic [1:0]        duty_q, duty_d;
  logic [7:0]        env_q, env_d;
  logic [FREQ_W-1:0] freq_q, freq_d, tcnt_q, tcnt_d, shadow_q, shadow_d;
  logic              len_en_q, len_en_d;
  logic [2:0]        pos_q, pos_d, etimer_q, etimer_d;
  logic [3:0]        vol_q, vol_d, stimer_q, stimer_d;
  logic [LEN_W-1:0]  lcnt_q, lcnt_d;
  logic              len_exp_q, len_exp_d, sweep_on_q, sweep_on_d, active_q, active_d;
  logic [1:0]        fc_q, fc_d;
  logic [FREQ_W:0]   nf;
  logic              trig, len_wr;
  logic [7:0]        pat;
`ifdef PULSE_CUSTOM_DUTY_EN
  logic [7:0]        dutypat_q, dutypat_d;
`endif

  // Next sweep frequency, one bit wider than freq so an upward overflow is visible.
  function automatic logic [FREQ_W:0] sweep_nf(input logic [FREQ_W-1:0] f, input logic ng,
                                               input logic [2:0] s);
    logic [FREQ_W:0] base, delta;
    base  = {1'b0, f};
    delta = base >> s;
    return ng ? base - delta : base + delta;
  endfunction

  function automatic logic sweep_ovf(input logic [FREQ_W-1:0] f, input logic ng,
                                     input logic [2:0] s);
    logic [FREQ_W:0] r;
    r = sweep_nf(f, ng, s);
    return r > {1'b0, {FREQ_W{1'b1}}};
  endfunction

  always_comb begin
    per_d = per_q; sh_d = sh_q; neg_d = neg_q; duty_d = duty_q; env_d = env_q;
    freq_d = freq_q; tcnt_d = tcnt_q; shadow_d = shadow_q; len_en_d = len_en_q;
    pos_d = pos_q; etimer_d = etimer_q; vol_d = vol_q; stimer_d = stimer_q;
    lcnt_d = lcnt_q; len_exp_d = len_exp_q; sweep_on_d = sweep_on_q; active_d = active_q;
    nf = '0;
`ifdef PULSE_CUSTOM_DUTY_EN
    dutypat_d = dutypat_q;
`endif
    trig   = write && (addr == 3'd4) && wdata[7];
    len_wr = write && (addr == 3'd1);
    fc_d   = fc_q + 2'(clk256_en);

    if (slow_clk_en) begin
      if (tcnt_q == '0) begin
        tcnt_d = ~freq_q;
        pos_d  = pos_q + 3'd1;
      end else begin
        tcnt_d = tcnt_q - FREQ_W'(1);
      end
    end

    // Frame ticks are suppressed by a trigger in the same cycle.
    if (clk256_en && !trig && !len_wr && len_en_q && !len_exp_q) begin
      lcnt_d = lcnt_q + LEN_W'(1);
      if (&lcnt_q) begin
        len_exp_d = 1'b1;
        active_d  = 1'b0;
      end
    end

    if (clk256_en && (fc_q == 2'd3) && !trig && (env_q[2:0] != 3'd0)) begin
      if (etimer_q <= 3'd1) begin
        etimer_d = env_q[2:0];
        if (env_q[3] && (vol_q != 4'hf)) vol_d = vol_q + 4'd1;
        else if (!env_q[3] && (vol_q != 4'h0)) vol_d = vol_q - 4'd1;
      end else begin
        etimer_d = etimer_q - 3'd1;
      end
    end

    if ((HAS_SWEEP != 0) && clk256_en && fc_q[0] && !trig && sweep_on_q) begin
      if (stimer_q <= 4'd1) begin
        stimer_d = (per_q == 3'd0) ? 4'd8 : {1'b0, per_q};
        if (per_q != 3'd0) begin
          nf = sweep_nf(shadow_q, neg_q, sh_q);
          if (nf[FREQ_W]) begin
            active_d = 1'b0;
          end else if (sh_q != 3'd0) begin
            freq_d   = nf[FREQ_W-1:0];
            shadow_d = nf[FREQ_W-1:0];
            if (sweep_ovf(nf[FREQ_W-1:0], neg_q, sh_q)) active_d = 1'b0;
          end
        end
      end else begin
        stimer_d = stimer_q - 4'd1;
      end
    end

    if (write) begin
      case (addr)
        3'd0: if (HAS_SWEEP != 0) {per_d, neg_d, sh_d} = wdata[6:0];
        3'd1: begin
          duty_d    = wdata[7:6];
          lcnt_d    = wdata[LEN_W-1:0];
          len_exp_d = 1'b0;
        end
        3'd2: env_d = wdata;
        3'd3: freq_d[7:0] = wdata;
        3'd4: begin
          len_en_d           = wdata[6];
          freq_d[FREQ_W-1:8] = wdata[FREQ_W-9:0];
        end
`ifdef PULSE_CUSTOM_DUTY_EN
        3'd5: dutypat_d = wdata;
`endif
        default: ;
      endcase
    end

    if (trig) begin
      active_d   = (env_d[7:3] != 5'd0) &&
                   !((sh_q != 3'd0) && sweep_ovf(freq_d, neg_q, sh_q));
      tcnt_d     = ~freq_d;
      vol_d      = env_d[7:4];
      etimer_d   = env_d[2:0];
      shadow_d   = freq_d;
      stimer_d   = {1'b0, per_q};
      sweep_on_d = (per_q != 3'd0) || (sh_q != 3'd0);
      if (len_exp_q) begin
        lcnt_d    = '0;
        len_exp_d = 1'b0;
      end
    end

    if (env_d[7:3] == 5'd0) active_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_q <= '0; sh_q <= '0; neg_q <= 1'b0; duty_q <= '0; env_q <= '0;
      freq_q <= '0; tcnt_q <= '0; shadow_q <= '0; len_en_q <= 1'b0;
      pos_q <= '0; etimer_q <= '0; vol_q <= '0; stimer_q <= '0; lcnt_q <= '0;
      len_exp_q <= 1'b0; sweep_on_q <= 1'b0; active_q <= 1'b0; fc_q <= '0;
`ifdef PULSE_CUSTOM_DUTY_EN
      dutypat_q <= '0;
`endif
    end else begin
      per_q <= per_d; sh_q <= sh_d; neg_q <= neg_d; duty_q <= duty_d; env_q <= env_d;
      freq_q <= freq_d; tcnt_q <= tcnt_d; shadow_q <= shadow_d; len_en_q <= len_en_d;
      pos_q <= pos_d; etimer_q <= etimer_d; vol_q <= vol_d; stimer_q <= stimer_d;
      lcnt_q <= lcnt_d; len_exp_q <= len_exp_d; sweep_on_q <= sweep_on_d;
      active_q <= active_d; fc_q <= fc_d;
`ifdef PULSE_CUSTOM_DUTY_EN
      dutypat_q <= dutypat_d;
`endif
    end
  end

  // Pattern bit p is the output level at sequencer position p.
  always_comb begin
    case (duty_q)
      2'd0:    pat = 8'b1000_0000;
      2'd1:    pat = 8'b1000_0001;
      2'd2:    pat = 8'b1110_0001;
`ifdef PULSE_CUSTOM_DUTY_EN
      default: pat = dutypat_q;
`else
      default: pat = 8'b0111_1110;
`endif
    endcase
  end

  always_comb begin
    case (addr)
      3'd0:    rdata = (HAS_SWEEP != 0) ? {1'b1, per_q, neg_q, sh_q} : 8'hff;
      3'd1:    rdata = {duty_q, 6'h3f};
      3'd2:    rdata = env_q;
      3'd4:    rdata = {1'b1, len_en_q, 6'h3f};
`ifdef PULSE_CUSTOM_DUTY_EN
      3'd5:    rdata = dutypat_q;
`endif
      default: rdata = 8'hff;
    endcase
  end

  assign active     = active_q;
  assign volume_out = active_q ? vol_q : 4'h0;
  assign wave       = (active_q && pat[pos_q]) ? vol_q : 4'h0;

endmodule

// File: tb/tb_pulse_channel_gen.sv
// Directed bench for pulse_channel_gen: period, length, envelope, sweep, reset and coincidence cases.
module tb_pulse_channel_gen;
  logic       clk = 1'b0, reset = 1'b0, slow_clk_en = 1'b0, clk256_en = 1'b0, write = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic [3:0] wave, volume_out;
  logic       active;

  int checks = 0, failures = 0, tb_fc = 0;
  logic [31:0] exp_q[$];

  pulse_channel_gen dut (
    .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .clk256_en(clk256_en),
    .addr(addr), .wdata(wdata), .write(write), .rdata(rdata), .wave(wave),
    .volume_out(volume_out), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; wdata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, {24'h0, rdata}, {24'h0, exp});
  endtask

  task automatic tick();
    clk256_en = 1'b1;
    @(posedge clk); #1;
    clk256_en = 1'b0;
    tb_fc = (tb_fc + 1) % 4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d2;
    int v;
    bit was_sweep;

    // Reset state
    #12;
    chk("rst_active", active, 0);
    chk("rst_wave", wave, 0);
    chk("rst_volume", volume_out, 0);
    rd_chk("rst_rd_sweep", 3'd0, 8'h80);
    rd_chk("rst_rd_len", 3'd1, 8'h3f);
    rd_chk("rst_rd_env", 3'd2, 8'h00);
    rd_chk("rst_rd_flo", 3'd3, 8'hff);
    rd_chk("rst_rd_ctrl", 3'd4, 8'hbf);
    rd_chk("rst_rd_pat", 3'd5, 8'hff);
    rd_chk("rst_rd_a6", 3'd6, 8'hff);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Period: freq = 0x7FC gives 4 enables per step, duty 2 pattern
    wr(3'd2, 8'hf0);
    wr(3'd1, 8'h80);
    wr(3'd3, 8'hfc);
    wr(3'd4, 8'h87);
    chk("period_active", active, 1);
    chk("period_wave0", wave, 15);
    d2 = 8'b10000111;
    for (int k = 1; k <= 32; k++) exp_q.push_back(d2[7 - ((k / 4) % 8)] ? 32'd15 : 32'd0);
    slow_clk_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      pop_chk("period_wave", wave);
    end
    slow_clk_en = 1'b0;

    // Length: 62 expires on the 2nd tick, retrigger runs 64 ticks
    wr(3'd1, 8'hbe);
    wr(3'd4, 8'hc7);
    chk("len_trig", active, 1);
    tick();
    chk("len_tick1", active, 1);
    tick();
    chk("len_expire", active, 0);
    wr(3'd4, 8'hc7);
    chk("len_retrig", active, 1);
    rd_chk("rd_ctrl_lenen", 3'd4, 8'hff);
    for (int i = 1; i <= 64; i++) exp_q.push_back((i < 64) ? 32'd1 : 32'd0);
    for (int i = 1; i <= 64; i++) begin
      tick();
      pop_chk("len_run", active);
    end

    // Envelope: up from 1, one step per fc = 3 tick, saturating at 15
    wr(3'd2, 8'h19);
    rd_chk("rd_env", 3'd2, 8'h19);
    wr(3'd1, 8'h00);
    wr(3'd4, 8'h87);
    chk("env_start", volume_out, 1);
    v = 1;
    for (int i = 0; i < 64; i++) begin
      if (tb_fc == 3 && v < 15) v++;
      exp_q.push_back(v);
      tick();
      pop_chk("env_vol", volume_out);
    end
    wr(3'd2, 8'h00);
    chk("dac_off_active", active, 0);
    chk("dac_off_volume", volume_out, 0);

    // Sweep overflow detected at trigger
    wr(3'd2, 8'hf0);
    wr(3'd0, 8'h11);
    rd_chk("rd_sweep_up", 3'd0, 8'h91);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h87);
    chk("sweep_ovf_trig", active, 0);

    // Sweep step downward: 0x100 -> 0x080 -> 0x040
    wr(3'd0, 8'h19);
    rd_chk("rd_sweep_neg", 3'd0, 8'h99);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h81);
    chk("sweep_trig_active", active, 1);
    chk("sweep_freq0", dut.freq_q, 32'h100);
    exp_q.push_back(32'h080);
    exp_q.push_back(32'h040);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      was_sweep = (tb_fc % 2) == 1;
      tick();
      if (was_sweep) pop_chk("sweep_freq", dut.freq_q);
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sweep_ticks observed=%0d pending expected=0", exp_q.size());
      exp_q.delete();
    end
    chk("sweep_still_active", active, 1);
    chk("sweep_volume", volume_out, 15);

    // Asynchronous reset mid-play, observed before any clock edge
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_active", active, 0);
    chk("arst_wave", wave, 0);
    chk("arst_volume", volume_out, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tb_fc = 0;
    @(posedge clk); #1;

    // Trigger coincident with a frame tick on an expired length counter
    wr(3'd2, 8'hf0);
    wr(3'd1, 8'h3f);
    wr(3'd4, 8'hc7);
    chk("coin_trig", active, 1);
    tick();
    chk("coin_expired", active, 0);
    addr = 3'd4; wdata = 8'hc7; write = 1'b1; clk256_en = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; clk256_en = 1'b0;
    tb_fc = (tb_fc + 1) % 4;
    chk("coin_active", active, 1);
    chk("coin_lcnt", dut.lcnt_q, 0);

    // Trigger with the DAC off keeps the channel silent
    wr(3'd2, 8'h00);
    wr(3'd4, 8'h80);
    chk("trig_dac_off", active, 0);
    rd_chk("rd_ctrl_nolen", 3'd4, 8'hbf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pulse_channel_gen.md
Name: pulse_channel_gen

Overview:
- Parametrised next-generation square-wave channel for the console APU.
- One self-contained module replaces the per-feature sub-block assembly. It contains the frequency timer, 8-step duty sequencer, volume envelope, length counter, a build-time-selectable frequency sweep and an internal frame divider.
- Register-addressed CPU port; the 4-bit sample feeds the APU mixer.

Parameters:
- FREQ_W, 11, frequency register width; legal 9..13.
- LEN_W, 6, length counter width; legal 1..6.
- HAS_SWEEP, 1, 1 = sweep unit present; 0 = sweep register reads 8'hff and writes are ignored.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- slow_clk_en  in  1  single-cycle enable that advances the frequency timer.
- clk256_en  in  1  single-cycle 256 Hz frame tick, independent of slow_clk_en.
- addr  in  3  register select 0..5.
- wdata  in  8  write data.
- write  in  1  register write strobe, one cycle.
- rdata  out  8  combinational readback of addr.
- wave  out  4  sample: vol when active and duty bit = 1, else 0.
- volume_out  out  4  vol when active, else 0.
- active  out  1  channel enabled.

Behaviour:
- Registers:
  - 0 SWEEP {-, per[6:4], neg[3], sh[2:0]}.
  - 1 LEN {duty[7:6], len[5:0]}; only len[LEN_W-1:0] is used.
  - 2 ENV {vol0[7:4], up[3], eper[2:0]}.
  - 3 FREQ_LO = freq[7:0].
  - 4 CTRL {trig[7], len_en[6], -, freq[FREQ_W-1:8] in bits[FREQ_W-9:0]}.
  - 5 DUTYPAT (optional feature).
- Readback:
  - Unimplemented bits read 1.
  - FREQ_LO and len read as all ones. CTRL reads {1, len_en, 6'h3f}. ENV reads back fully.
  - addr 6..7 read 8'hff.
- Reset (reset = 0), asynchronous:
  - All registers, timers, vol, duty position and frame counter are cleared to 0.
  - active = 0, wave = 0, volume_out = 0.
- DAC: dac_on = (ENV[7:3] != 0).
  - A write that makes dac_on = 0 clears active in the next cycle.
  - Trigger while dac_on = 0 leaves active = 0.
- Frame divider: 2-bit fc, incremented on clk256_en.
  - Length clocks on every tick.
  - Sweep clocks on ticks where fc[0] = 1 (128 Hz).
  - Envelope clocks on ticks where fc = 3 (64 Hz).
- Frequency timer: on slow_clk_en, tcnt decrements.
  - When tcnt = 0: reload tcnt = 2^FREQ_W - 1 - freq and advance pos = pos + 1 mod 8.
  - Step period is therefore 2^FREQ_W - freq enables.
- Duty patterns, pos 0..7 (bit per position, left to right = pos 0 to pos 7):
  - duty 0 = 00000001
  - duty 1 = 10000001
  - duty 2 = 10000111
  - duty 3 = 01111110
- Trigger (write addr 4 with wdata[7] = 1), state visible in the next cycle:
  - active = dac_on.
  - tcnt reloaded; pos is not reset.
  - vol = vol0; envelope timer = eper.
  - If the length counter had expired, it reloads to 0.
  - Sweep: shadow = freq, stimer = per, sweep_on = (per != 0 or sh != 0). If sh != 0, run the overflow check immediately; overflow clears active.
- Length counter:
  - A write to len loads lcnt = len.
  - On a length tick with len_en = 1 and not expired: lcnt = lcnt + 1. Wrap from 2^LEN_W - 1 sets expired and clears active.
- Envelope: on an envelope tick with eper != 0, etimer decrements.
  - At 0: reload to eper; vol = vol ± 1 per up.
  - vol saturates at 15 and 0 (no wrap).
- Sweep (HAS_SWEEP = 1): on a sweep tick with sweep_on, stimer decrements.
  - At 0: reload stimer = per (8 when per = 0).
  - If per != 0: nf = shadow ± (shadow >> sh), computed in FREQ_W + 1 bits.
  - If nf ≥ 2^FREQ_W: clear active.
  - Else if sh != 0: freq = shadow = nf, then run a second overflow check.
  - neg = 1 never overflows.
- Simultaneous events:
  - A CPU write beats a tick on the same field.
  - A trigger beats a length, envelope or sweep tick in the same cycle.
  - A sweep write-back in the same cycle as a CPU FREQ write: the CPU value wins.

Optional Feature:
- Macro: PULSE_CUSTOM_DUTY_EN.
- Defined:
  - addr 5 is an 8-bit pattern register, reset 8'h00, read back fully.
  - duty = 3 selects this pattern instead of 01111110.
- Undefined:
  - addr 5 reads 8'hff and writes are ignored.
  - duty = 3 is the fixed 75% pattern.

Test Plan:
- Period: ENV = F0, duty = 2, freq = 2^FREQ_W - 4, trigger, pulse slow_clk_en every cycle -> pos advances every 4 enables; wave shows 1,0,0,0,0,1,1,1 × 15 per 4-enable step.
- Length: LEN_W = 6, len = 62, len_en = 1, trigger -> active falls exactly after the 2nd clk256_en; retrigger without a len write -> runs 64 ticks.
- Envelope: ENV = 0x19 (vol0 = 1, up, eper = 1) -> vol 1→2→…→15 on successive fc = 3 ticks, holds at 15; ENV = 0x00 mid-play -> active = 0 next cycle.
- Sweep overflow: FREQ_W = 11, freq = 0x700, SWEEP = 0x11 (per = 1, up, sh = 1), trigger -> 0x700 + 0x380 ≥ 0x800, active = 0 in the trigger response.
- Sweep step: freq = 0x100, SWEEP = 0x19 (per = 1, neg, sh = 1) -> freq 0x080 after the first sweep tick, 0x040 after the next.
- Reset and coincidence: assert reset low mid-play -> all outputs 0 with no clock edge; trigger coincident with clk256_en on an expired length -> lcnt = 0 and active = 1.
